// File: rtl/rfphoenix_ifetch_queue.sv
// rfphoenix_ifetch_queue: fetch-to-decode instruction queue that merges PFX prefix words into the next instruction.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : drop queued words, held prefix and output bundle
//   fetch_v/insn/pc/rdy   : fetch-side push handshake
//   dec_v/insn/pfx_v/pfx_imm/pc/rdy : registered decode bundle with valid/ready
//   count                 : words held in the circular buffer
module rfphoenix_ifetch_queue #(
    parameter int         DEPTH       = 4,
    parameter int         INSN_W      = 40,
    parameter logic [5:0] PFX_OPC     = 6'h3F,
    parameter int         PFX_IMM_LSB = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_v,
    input  logic [INSN_W-1:0]          fetch_insn,
    input  logic [31:0]                fetch_pc,
    output logic                       fetch_rdy,
    output logic                       dec_v,
    output logic [INSN_W-1:0]          dec_insn,
    output logic                       dec_pfx_v,
    output logic [15:0]                dec_pfx_imm,
    output logic [31:0]                dec_pc,
    input  logic                       dec_rdy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSN_W-1:0] mem_insn [DEPTH];
    logic [31:0]       mem_pc   [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              pfx_held;
    logic [15:0]       pfx_imm;
    logic [31:0]       pfx_pc;
    logic              push, out_load, pop, head_pfx;
    logic [INSN_W-1:0] head_insn;
    logic [31:0]       head_pc;

    // fetch_rdy looks only at the registered count, so a full queue refuses a push even if it pops that cycle
    assign fetch_rdy = count != CW'(DEPTH);
    assign push      = fetch_v && fetch_rdy && !flush;
    assign out_load  = !dec_v || dec_rdy;
    assign pop       = out_load && count != '0;
    assign head_insn = mem_insn[rd_ptr];
    assign head_pc   = mem_pc[rd_ptr];
    assign head_pfx  = head_insn[5:0] == PFX_OPC;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wr_ptr] <= fetch_insn;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pfx_held    <= 1'b0;
            pfx_imm     <= '0;
            pfx_pc      <= '0;
            dec_v       <= 1'b0;
            dec_insn    <= '0;
            dec_pfx_v   <= 1'b0;
            dec_pfx_imm <= '0;
            dec_pc      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            // a popped prefix leaves a bubble; a later prefix overwrites an earlier one
            if (pop) begin
                pfx_held <= head_pfx;
                if (head_pfx) begin
                    pfx_imm <= head_insn[PFX_IMM_LSB +: 16];
                    pfx_pc  <= head_pc;
                end
            end
            if (out_load) begin
                dec_v       <= pop && !head_pfx;
                dec_pfx_v   <= pop && !head_pfx && pfx_held;
                dec_pfx_imm <= (pop && !head_pfx && pfx_held) ? pfx_imm : 16'h0;
                if (pop && !head_pfx) begin
                    dec_insn <= head_insn;
                    dec_pc   <= pfx_held ? pfx_pc : head_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_rfphoenix_ifetch_queue.sv
// tb_rfphoenix_ifetch_queue: directed self-checking bench for rfphoenix_ifetch_queue.
module tb_rfphoenix_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst, flush, fetch_v, fetch_rdy, dec_v, dec_pfx_v, dec_rdy;
    logic [39:0] fetch_insn, dec_insn;
    logic [31:0] fetch_pc, dec_pc;
    logic [15:0] dec_pfx_imm;
    logic [2:0]  count;
    int          n_chk = 0;
    int          n_fail = 0;

    rfphoenix_ifetch_queue #(.DEPTH(4), .INSN_W(40), .PFX_OPC(6'h3F), .PFX_IMM_LSB(24)) dut (
        .clk(clk), .rst(rst), .flush(flush), .fetch_v(fetch_v), .fetch_insn(fetch_insn),
        .fetch_pc(fetch_pc), .fetch_rdy(fetch_rdy), .dec_v(dec_v), .dec_insn(dec_insn),
        .dec_pfx_v(dec_pfx_v), .dec_pfx_imm(dec_pfx_imm), .dec_pc(dec_pc), .dec_rdy(dec_rdy),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [39:0] insn, input logic [31:0] pc);
        fetch_v    = v;
        fetch_insn = insn;
        fetch_pc   = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; dec_rdy = 1'b0; drive(1'b0, '0, '0);
        tick(); tick();
        rst = 1'b0;
        n_chk++; if (dec_v !== 1'b0) begin n_fail++; $display("FAIL reset_dec_v got %b exp 0", dec_v); end
        n_chk++; if (dec_pfx_v !== 1'b0) begin n_fail++; $display("FAIL reset_pfx_v got %b exp 0", dec_pfx_v); end
        n_chk++; if (dec_pfx_imm !== 16'h0) begin n_fail++; $display("FAIL reset_imm got %h exp 0", dec_pfx_imm); end
        n_chk++; if (dec_insn !== 40'h0) begin n_fail++; $display("FAIL reset_insn got %h exp 0", dec_insn); end
        n_chk++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", dec_pc); end
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_chk++; if (fetch_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_rdy got %b exp 1", fetch_rdy); end
    endtask

    task automatic test_streaming();
        logic [39:0] w [3] = '{40'h00000A0001, 40'h00000B0001, 40'h00000C0001};
        logic [31:0] p [3] = '{32'h100, 32'h105, 32'h10A};
        dec_rdy = 1'b1;
        drive(1'b1, w[0], p[0]);
        tick();
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL stream_first got dec_v %b count %0d exp 0 1", dec_v, count); end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, w[i+1], p[i+1]); else drive(1'b0, '0, '0);
            tick();
            n_chk++; if (dec_v !== 1'b1 || dec_insn !== w[i] || dec_pc !== p[i]) begin n_fail++; $display("FAIL stream_bundle%0d got v %b insn %h pc %h exp 1 %h %h", i, dec_v, dec_insn, dec_pc, w[i], p[i]); end
            n_chk++; if (dec_pfx_v !== 1'b0 || count > 3'd1) begin n_fail++; $display("FAIL stream_pfx_count%0d got pfx %b count %0d exp 0 <=1", i, dec_pfx_v, count); end
        end
        tick();
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL stream_drain got v %b count %0d exp 0 0", dec_v, count); end
    endtask

    task automatic test_prefix_merge();
        dec_rdy = 1'b1;
        drive(1'b1, 40'hBEEF00003F, 32'h200);
        tick();
        drive(1'b1, 40'h0000123401, 32'h205);
        tick();
        n_chk++; if (dec_v !== 1'b0) begin n_fail++; $display("FAIL pfx_bubble got dec_v %b exp 0", dec_v); end
        drive(1'b0, '0, '0);
        tick();
        n_chk++; if (dec_v !== 1'b1 || dec_insn !== 40'h0000123401) begin n_fail++; $display("FAIL pfx_insn got v %b insn %h exp 1 0000123401", dec_v, dec_insn); end
        n_chk++; if (dec_pfx_v !== 1'b1 || dec_pfx_imm !== 16'hBEEF || dec_pc !== 32'h200) begin n_fail++; $display("FAIL pfx_attach got pfx %b imm %h pc %h exp 1 beef 200", dec_pfx_v, dec_pfx_imm, dec_pc); end
        drive(1'b1, 40'h0000567801, 32'h20A);
        tick();
        drive(1'b0, '0, '0);
        tick();
        n_chk++; if (dec_v !== 1'b1 || dec_insn !== 40'h0000567801 || dec_pfx_v !== 1'b0 || dec_pfx_imm !== 16'h0 || dec_pc !== 32'h20A) begin n_fail++; $display("FAIL pfx_next got v %b insn %h pfx %b imm %h pc %h exp 1 0000567801 0 0 20a", dec_v, dec_insn, dec_pfx_v, dec_pfx_imm, dec_pc); end
        tick();
    endtask

    task automatic test_double_prefix();
        dec_rdy = 1'b1;
        drive(1'b1, 40'h111100003F, 32'h300);
        tick();
        drive(1'b1, 40'h222200003F, 32'h305);
        tick();
        n_chk++; if (dec_v !== 1'b0) begin n_fail++; $display("FAIL dpfx_bubble1 got dec_v %b exp 0", dec_v); end
        drive(1'b1, 40'h0000999901, 32'h30A);
        tick();
        n_chk++; if (dec_v !== 1'b0) begin n_fail++; $display("FAIL dpfx_bubble2 got dec_v %b exp 0", dec_v); end
        drive(1'b0, '0, '0);
        tick();
        n_chk++; if (dec_v !== 1'b1 || dec_insn !== 40'h0000999901 || dec_pfx_imm !== 16'h2222 || dec_pc !== 32'h305 || dec_pfx_v !== 1'b1) begin n_fail++; $display("FAIL dpfx_bundle got v %b insn %h pfx %b imm %h pc %h exp 1 0000999901 1 2222 305", dec_v, dec_insn, dec_pfx_v, dec_pfx_imm, dec_pc); end
        tick();
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL dpfx_single got v %b count %0d exp 0 0", dec_v, count); end
    endtask

    task automatic test_backpressure_full();
        logic [39:0] w [6];
        logic [31:0] p [6];
        for (int i = 0; i < 6; i++) begin
            w[i] = {32'h00000D00 + 32'(i), 8'h01};
            p[i] = 32'h400 + 32'(5 * i);
        end
        dec_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, w[i], p[i]);
            tick();
        end
        n_chk++; if (count !== 3'd4 || fetch_rdy !== 1'b0) begin n_fail++; $display("FAIL full_count got count %0d rdy %b exp 4 0", count, fetch_rdy); end
        drive(1'b1, w[5], p[5]);
        tick();
        n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refuse got count %0d exp 4", count); end
        n_chk++; if (dec_v !== 1'b1 || dec_insn !== w[0] || dec_pc !== p[0]) begin n_fail++; $display("FAIL full_hold got v %b insn %h pc %h exp 1 %h %h", dec_v, dec_insn, dec_pc, w[0], p[0]); end
        drive(1'b0, '0, '0);
        dec_rdy = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            n_chk++; if (dec_v !== 1'b1 || dec_insn !== w[i] || dec_pc !== p[i] || count !== 3'(4 - i)) begin n_fail++; $display("FAIL full_drain%0d got v %b insn %h pc %h count %0d exp 1 %h %h %0d", i, dec_v, dec_insn, dec_pc, count, w[i], p[i], 4 - i); end
        end
        tick();
        n_chk++; if (dec_v !== 1'b0) begin n_fail++; $display("FAIL full_empty got dec_v %b exp 0", dec_v); end
    endtask

    task automatic test_flush();
        dec_rdy = 1'b0;
        drive(1'b1, 40'h0000F00001, 32'h500); tick();
        drive(1'b1, 40'hABCD00003F, 32'h505); tick();
        drive(1'b1, 40'h0000F10001, 32'h50A); tick();
        drive(1'b1, 40'h0000F20001, 32'h50F); tick();
        drive(1'b1, 40'h0000F30001, 32'h514); tick();
        drive(1'b0, '0, '0);
        dec_rdy = 1'b1;
        tick();
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd3) begin n_fail++; $display("FAIL flush_setup got v %b count %0d exp 0 3", dec_v, count); end
        flush = 1'b1;
        drive(1'b1, 40'h0000F40001, 32'h519);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd0 || fetch_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_state got v %b count %0d rdy %b exp 0 0 1", dec_v, count, fetch_rdy); end
        tick();
        n_chk++; if (dec_v !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL flush_discard got v %b count %0d exp 0 0", dec_v, count); end
        drive(1'b1, 40'h0000777701, 32'h777);
        tick();
        drive(1'b0, '0, '0);
        tick();
        n_chk++; if (dec_v !== 1'b1 || dec_insn !== 40'h0000777701 || dec_pfx_v !== 1'b0 || dec_pfx_imm !== 16'h0 || dec_pc !== 32'h777) begin n_fail++; $display("FAIL flush_after got v %b insn %h pfx %b imm %h pc %h exp 1 0000777701 0 0 777", dec_v, dec_insn, dec_pfx_v, dec_pfx_imm, dec_pc); end
        tick();
    endtask

    task automatic test_wrap_reset();
        logic [39:0] w [10];
        logic [31:0] p [10];
        int sent = 0;
        int got = 0;
        logic do_push;
        for (int i = 0; i < 10; i++) begin
            w[i] = {32'h00000E00 + 32'(i), 8'h02};
            p[i] = 32'h600 + 32'(4 * i);
        end
        for (int c = 0; c < 300 && got < 10; c++) begin
            dec_rdy = 1'($urandom_range(0, 1));
            if (sent < 10) drive(1'b1, w[sent], p[sent]); else drive(1'b0, '0, '0);
            do_push = fetch_v && fetch_rdy;
            if (dec_v && dec_rdy) begin
                n_chk++; if (dec_insn !== w[got] || dec_pc !== p[got]) begin n_fail++; $display("FAIL wrap_word%0d got %h pc %h exp %h %h", got, dec_insn, dec_pc, w[got], p[got]); end
                got++;
            end
            tick();
            if (do_push) sent++;
        end
        n_chk++; if (got != 10) begin n_fail++; $display("FAIL wrap_delivered got %0d exp 10", got); end
        dec_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, w[i], p[i]);
            tick();
        end
        n_chk++; if (dec_v !== 1'b1 || count !== 3'd2) begin n_fail++; $display("FAIL rst_setup got v %b count %0d exp 1 2", dec_v, count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0);
        n_chk++; if (dec_v !== 1'b0 || dec_pfx_v !== 1'b0 || dec_pfx_imm !== 16'h0 || dec_insn !== 40'h0 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL rst_outputs got v %b pfx %b imm %h insn %h pc %h exp all 0", dec_v, dec_pfx_v, dec_pfx_imm, dec_insn, dec_pc); end
        n_chk++; if (count !== 3'd0 || fetch_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_count got count %0d rdy %b exp 0 1", count, fetch_rdy); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_prefix_merge();
        test_double_prefix();
        test_backpressure_full();
        test_flush();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
